// File: rtl/ser_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Define SER_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module ser_frame_rx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    output logic [DATA_W-1:0] out_comp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shift_reg;
    logic               last_bit_c;
    logic               stop_good_c;

    assign last_bit_c = (bit_cnt == CNT_W'(DATA_W - 1));

`ifdef SER_PARITY_EN
    logic par_bad;
    assign stop_good_c = sin & ~par_bad;
`else
    assign stop_good_c = sin;
    assign parity_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!sin) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (last_bit_c) begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY:  state_nxt = STOP;
`endif
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter, output word and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            out_comp  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SER_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                DATA: begin
                    shift_reg <= DATA_W'({sin, shift_reg} >> 1);
                    bit_cnt   <= last_bit_c ? '0 : bit_cnt + CNT_W'(1);
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    par_bad <= (sin != ^shift_reg);
                end
`endif
                STOP: begin
                    frame_err <= ~sin;
`ifdef SER_PARITY_EN
                    parity_err <= par_bad;
`endif
                    // A pending word is only replaced if it is being consumed this cycle
                    if (stop_good_c) begin
                        if (!out_valid || out_ready) begin
                            out_comp  <= shift_reg;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_frame_rx.sv
// Directed bench for ser_frame_rx: table of single frames plus hand sequences
// for reset, overrun, simultaneous complete/accept and mid-frame reset.
module tb_ser_frame_rx;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              sin;
    logic [DATA_W-1:0] out_comp;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    int ncmp  = 0;
    int nfail = 0;

    ser_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .out_comp   (out_comp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       flip;      // send wrong parity bit (parity builds only)
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    // Start bit, data LSB first, optional parity, stop. Outputs for the stop
    // sample are visible after the next drive().
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                              input logic rdy_at_stop);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(d[i]);
`ifdef SER_PARITY_EN
        drive((^d) ^ flip);
`else
        if (flip) begin end
`endif
        drive(stop);
        if (rdy_at_stop) out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic exp_perr;
        logic exp_valid;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h07, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'hC3, 1'b0, 1'b1, 1'b1};

        // Reset held 3 cycles with sin low
        reset = 1'b1; sin = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {out_valid, frame_err, overrun, parity_err, out_comp},
                  32'h0);
        end
        reset = 1'b0; sin = 1'b1;
        drive(1'b1);

        // Table-driven single frames, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[k]) begin
`ifdef SER_PARITY_EN
            exp_perr = vecs[k].flip;
`else
            exp_perr = 1'b0;
`endif
            exp_valid = vecs[k].stop & ~exp_perr;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].flip, 1'b0);
            drive(1'b1);
            check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(exp_valid));
            if (exp_valid) check($sformatf("vec%0d_comp", k), 32'(out_comp), 32'(vecs[k].data));
            check($sformatf("vec%0d_ferr", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d_perr", k), 32'(parity_err), 32'(exp_perr));
            check($sformatf("vec%0d_ovr", k), 32'(overrun), 32'h0);
            drive(1'b1);
            check($sformatf("vec%0d_drop", k), 32'({out_valid, frame_err, parity_err}), 32'h0);
        end

        // Overrun: two back-to-back good frames with no consumer
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        drive(1'b1);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_valid", 32'(out_valid), 32'h1);
        check("ovr_keep_old", 32'(out_comp), 32'h11);
        drive(1'b1);
        check("ovr_one_cycle", 32'(overrun), 32'h0);
        check("ovr_still_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        drive(1'b1);
        check("ovr_accept_drop", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Simultaneous complete/accept: new word replaces the pending one
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        drive(1'b1);
        check("sim_pending", 32'(out_comp), 32'h11);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        drive(1'b1);
        out_ready = 1'b0;
        check("sim_valid", 32'(out_valid), 32'h1);
        check("sim_comp", 32'(out_comp), 32'h22);
        check("sim_no_ovr", 32'(overrun), 32'h0);
        drive(1'b1);
        check("sim_hold", 32'({out_valid, out_comp}), 32'h122);
        out_ready = 1'b1;
        drive(1'b1);
        check("sim_drop", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Mid-frame reset with a pending word, then normal reception
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        drive(1'b1);
        check("mr_pending", 32'({out_valid, out_comp}), 32'h133);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        reset = 1'b1;
        drive(1'b1);
        reset = 1'b0;
        check("mr_reset_outputs", {out_valid, frame_err, overrun, parity_err, out_comp}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1);
            check("mr_no_pulse", 32'({out_valid, frame_err, overrun, parity_err}), 32'h0);
        end
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        drive(1'b1);
        check("mr_resume", 32'({out_valid, out_comp}), 32'h15A);

        // out_ready with nothing pending has no effect
        drive(1'b1);
        drive(1'b1);
        check("idle_ready", 32'({out_valid, overrun, frame_err}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
